// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and helpers for the serial audio transmitter
//
// Purpose: format encodings, bit-counter sizing and a constant log2 helper
// used by audio_i2s_tx and audio_tx_fifo.
// Ports: none (package).
// Optional feature macro used by the top: AUDIO_TX_UNDERRUN_CNT_EN.

package audio_pkg;

  localparam logic FMT_I2S = 1'b0;
  localparam logic FMT_RJ  = 1'b1;

  localparam int              CNT_W   = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

  // Smallest r with 2**r >= value; bounded loop so it elaborates as a constant.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_tx_fifo.sv
// rtl/audio_tx_fifo.sv - single-clock stereo frame FIFO for the audio transmitter
//
// Purpose: DEPTH x WIDTH frame store between user logic and the LRC-timed
// serialiser. Write side is valid/ready, read side is pop/empty with the head
// word presented combinationally.
// Ports:
//   aud_bclk  in   clock
//   rst_n     in   asynchronous active-low reset (empties the FIFO)
//   wr_valid  in   write request
//   wr_ready  out  not full; a write is taken only when both are high
//   wr_data   in   WIDTH-bit frame
//   rd_pop    in   pop request (ignored while empty)
//   rd_empty  out  no frames stored
//   rd_data   out  head frame

module audio_tx_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             aud_bclk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_pop,
  output logic             rd_empty,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W    = clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic                do_push;
  logic                do_pop;

  // A full FIFO refuses writes even when a pop happens in the same cycle,
  // and an empty FIFO never forwards a same-cycle write to the read side.
  assign wr_ready = (count != FULL_CNT);
  assign rd_empty = (count == '0);
  assign do_push  = wr_valid && wr_ready;
  assign do_pop   = rd_pop && !rd_empty;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge aud_bclk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - I2S / right-justified serial audio transmitter (codec slave)
//
// Purpose: accepts stereo frames through a FIFO and serialises them onto the
// codec DAC pin, timed by the codec's aud_bclk and aud_lrc.
// Optional feature: define AUDIO_TX_UNDERRUN_CNT_EN to add a saturating
// underrun counter (underrun_cnt) with a synchronous clear (underrun_clr).
// Ports:
//   aud_bclk      in   codec bit clock, sole clock
//   rst_n         in   asynchronous active-low reset
//   aud_lrc       in   LR clock, 0 = left, 1 = right
//   fmt           in   0 = I2S, 1 = right-justified; latched at left edge
//   in_valid      in   frame present
//   in_ready      out  FIFO not full
//   in_left       in   WL-bit left sample
//   in_right      in   WL-bit right sample
//   aud_dacdat    out  serial data, updated on falling aud_bclk
//   tx_done       out  pulse: a channel word slot has ended
//   tx_ch         out  channel tx_done refers to (0 = L, 1 = R)
//   underrun      out  pulse: left-edge pop found FIFO empty
//   underrun_clr  in   (optional) clear the underrun counter
//   underrun_cnt  out  (optional) saturating underrun count

module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int WL              = 24,
  parameter int SLOT            = 32,
  parameter int DEPTH           = 4,
  parameter int UNDERRUN_REPEAT = 0
) (
  input  logic          aud_bclk,
  input  logic          rst_n,
  input  logic          aud_lrc,
  input  logic          fmt,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_left,
  input  logic [WL-1:0] in_right,
  output logic          aud_dacdat,
  output logic          tx_done,
  output logic          tx_ch,
  output logic          underrun
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
  ,
  input  logic [0:0]    underrun_clr,
  output logic [15:0]   underrun_cnt
`endif
);

  localparam int OFF   = SLOT - WL;
  localparam int IDX_W = clog2(WL);

  logic             lrc_d0;
  logic             lrc_edge;
  logic             left_edge;
  logic             right_edge;
  logic [CNT_W-1:0] cnt;
  logic [WL-1:0]    hold_l;
  logic [WL-1:0]    hold_r;
  logic [WL-1:0]    shift_q;
  logic             fmt_q;
  logic             armed;
  logic             fifo_empty;
  logic [2*WL-1:0]  fifo_head;
  logic [WL-1:0]    head_l;
  logic [WL-1:0]    head_r;
  logic             dac_next;
  logic [IDX_W-1:0] bit_idx;
  int               cnt_i;

  audio_tx_fifo #(
    .WIDTH (2*WL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aud_bclk (aud_bclk),
    .rst_n    (rst_n),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  ({in_left, in_right}),
    .rd_pop   (left_edge),
    .rd_empty (fifo_empty),
    .rd_data  (fifo_head)
  );

  assign head_l = fifo_head[2*WL-1:WL];
  assign head_r = fifo_head[WL-1:0];

  // lrc_d0 resets low, so an LRC already high at release is seen as an edge.
  assign lrc_edge   = aud_lrc ^ lrc_d0;
  assign left_edge  = lrc_edge && !aud_lrc;
  assign right_edge = lrc_edge && aud_lrc;

  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      lrc_d0 <= 1'b0;
      cnt    <= '0;
    end else begin
      lrc_d0 <= aud_lrc;
      if (lrc_edge) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The whole stereo frame is taken at the left edge; the right word comes
  // from hold_r so a frame is never split across two FIFO entries.
  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_l   <= '0;
      hold_r   <= '0;
      shift_q  <= '0;
      fmt_q    <= FMT_I2S;
      underrun <= 1'b0;
    end else begin
      underrun <= left_edge && fifo_empty;
      if (left_edge) begin
        fmt_q <= fmt;
        if (!fifo_empty) begin
          hold_l  <= head_l;
          hold_r  <= head_r;
          shift_q <= head_l;
        end else if (UNDERRUN_REPEAT != 0) begin
          shift_q <= hold_l;
        end else begin
          hold_l  <= '0;
          hold_r  <= '0;
          shift_q <= '0;
        end
      end else if (right_edge) begin
        shift_q <= hold_r;
      end
    end
  end

  // The first edge after reset only arms reporting: the slot that preceded
  // it was never transmitted by this block.
  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      tx_done <= 1'b0;
      tx_ch   <= 1'b0;
    end else begin
      tx_done <= lrc_edge && armed;
      if (lrc_edge) begin
        armed <= 1'b1;
        tx_ch <= !aud_lrc;
      end
    end
  end

  // Bit selection by slot position. The word register is indexed rather than
  // shifted, so a short LRC half-period simply stops partway through the word.
  always_comb begin
    dac_next = 1'b0;
    bit_idx  = '0;
    cnt_i    = int'(cnt);
    case (fmt_q)
      FMT_I2S: begin
        if (cnt_i < WL) begin
          bit_idx  = IDX_W'(WL - 1 - cnt_i);
          dac_next = shift_q[bit_idx];
        end
      end
      FMT_RJ: begin
        if (cnt_i < OFF) begin
          dac_next = shift_q[WL-1];
        end else if (cnt_i < SLOT) begin
          bit_idx  = IDX_W'(WL - 1 - (cnt_i - OFF));
          dac_next = shift_q[bit_idx];
        end
      end
      default: dac_next = 1'b0;
    endcase
  end

  // Falling-edge launch gives the codec a full half period of setup before
  // it samples on the rising edge.
  always_ff @(negedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      aud_dacdat <= 1'b0;
    end else begin
      aud_dacdat <= dac_next;
    end
  end

`ifdef AUDIO_TX_UNDERRUN_CNT_EN
  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (underrun_clr[0]) begin
      underrun_cnt <= '0;
    end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - self-checking bench for audio_i2s_tx
module tb_audio_i2s_tx;

  logic aud_bclk = 1'b0;
  always #5 aud_bclk = ~aud_bclk;

  logic        rst_n;
  logic        aud_lrc;

  logic        fmt_a, in_valid_a, in_ready_a, dac_a, done_a, ch_a, und_a;
  logic [23:0] in_left_a, in_right_a;
  logic        fmt_b, in_valid_b, in_ready_b, dac_b, done_b, ch_b, und_b;
  logic [15:0] in_left_b, in_right_b;
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
  logic [0:0]  clr_a, clr_b;
  logic [15:0] ucnt_a, ucnt_b;
`endif

  audio_i2s_tx #(.WL(24), .SLOT(32), .DEPTH(4), .UNDERRUN_REPEAT(0)) dut_a (
    .aud_bclk   (aud_bclk),
    .rst_n      (rst_n),
    .aud_lrc    (aud_lrc),
    .fmt        (fmt_a),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .in_left    (in_left_a),
    .in_right   (in_right_a),
    .aud_dacdat (dac_a),
    .tx_done    (done_a),
    .tx_ch      (ch_a),
    .underrun   (und_a)
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
    ,
    .underrun_clr (clr_a),
    .underrun_cnt (ucnt_a)
`endif
  );

  audio_i2s_tx #(.WL(16), .SLOT(32), .DEPTH(4), .UNDERRUN_REPEAT(1)) dut_b (
    .aud_bclk   (aud_bclk),
    .rst_n      (rst_n),
    .aud_lrc    (aud_lrc),
    .fmt        (fmt_b),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_left    (in_left_b),
    .in_right   (in_right_b),
    .aud_dacdat (dac_b),
    .tx_done    (done_b),
    .tx_ch      (ch_b),
    .underrun   (und_b)
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
    ,
    .underrun_clr (clr_b),
    .underrun_cnt (ucnt_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_a, cap_b, done_mask_a, und_mask_a, und_mask_b;
  logic        ch1_a, ch33_a;
  logic        seen_done;

  typedef struct {
    logic        push_a;
    logic [23:0] la, ra;
    logic        fa;
    logic        flip;
    logic        epush;
    logic [23:0] el, er;
    logic        push_b;
    logic [15:0] lb, rb;
    logic        fb;
    logic [63:0] xa, xb;
    logic        ua, ub;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // One stereo frame: left edge at the first posedge after the call, 32 bclk
  // per half. Bit k of a slot is sampled just after the falling edge that
  // launches it; cap[63:32] is the left slot, cap[31:0] the right slot.
  task automatic run_frame(input logic flip_a, input logic edge_push,
                           input logic [23:0] el, input logic [23:0] er,
                           input logic clr_at_edge);
    @(negedge aud_bclk);
    aud_lrc = 1'b0;
    if (edge_push) begin
      in_valid_a = 1'b1;
      in_left_a  = el;
      in_right_a = er;
    end
    for (int i = 1; i <= 64; i++) begin
      @(negedge aud_bclk);
      if (i == 1) in_valid_a = 1'b0;
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
      if (i == 1) clr_a = clr_at_edge;
      if (i == 2) clr_a = 1'b0;
`endif
      if (i == 32) aud_lrc = 1'b1;
      if (i == 40 && flip_a) fmt_a = ~fmt_a;
      #1;
      cap_a[64-i]         = dac_a;
      cap_b[64-i]         = dac_b;
      done_mask_a[i-1]    = done_a;
      und_mask_a[i-1]     = und_a;
      und_mask_b[i-1]     = und_b;
      if (i == 1)  ch1_a  = ch_a;
      if (i == 33) ch33_a = ch_a;
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] xa, input logic ua);
    check({tag, "_dac_a"}, cap_a, xa);
    check({tag, "_und_a"}, und_mask_a, ua ? 64'h1 : 64'h0);
    check({tag, "_done_a"}, done_mask_a, 64'h0000_0001_0000_0001);
    check({tag, "_ch_at_left_edge"}, {63'b0, ch1_a}, 64'd1);
    check({tag, "_ch_at_right_edge"}, {63'b0, ch33_a}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic acc;
    rst_n = 1'b0;
    aud_lrc = 1'b1;
    fmt_a = 1'b0; in_valid_a = 1'b0; in_left_a = '0; in_right_a = '0;
    fmt_b = 1'b0; in_valid_b = 1'b0; in_left_b = '0; in_right_b = '0;
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
    clr_a = 1'b0; clr_b = 1'b0;
`endif

    vecs[0] = '{1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0,
                1'b0, 16'h0, 16'h0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0,
                1'b1, 16'h8001, 16'h1234, 1'b1,
                64'hA5A5A500_5A5A5A00, 64'hFFFF8001_00001234, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0,
                1'b0, 16'h0, 16'h0, 1'b1,
                64'h0, 64'hFFFF8001_00001234, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 24'h800000, 24'h000001, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0,
                1'b1, 16'hC3C3, 16'h0F0F, 1'b0,
                64'hFF800000_00000001, 64'hC3C30000_0F0F0000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 24'h123456, 24'hFEDCBA, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0,
                1'b1, 16'hFFFF, 16'h0001, 1'b1,
                64'h12345600_FEDCBA00, 64'hFFFFFFFF_00000001, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b1, 24'hABCDEF, 24'h654321,
                1'b0, 16'h0, 16'h0, 1'b1,
                64'h0, 64'hFFFFFFFF_00000001, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0,
                1'b0, 16'h0, 16'h0, 1'b1,
                64'hABCDEF00_65432100, 64'hFFFFFFFF_00000001, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge aud_bclk);
    #1;
    check("rst_dacdat", {63'b0, dac_a}, 64'd0);
    check("rst_tx_done", {63'b0, done_a}, 64'd0);
    check("rst_tx_ch", {63'b0, ch_a}, 64'd0);
    check("rst_underrun", {63'b0, und_a}, 64'd0);
    check("rst_in_ready_a", {63'b0, in_ready_a}, 64'd1);
    check("rst_in_ready_b", {63'b0, in_ready_b}, 64'd1);

    // Release with LRC high: first edge arms reporting without a pulse
    @(negedge aud_bclk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aud_bclk);
      #1;
      seen_done = seen_done | done_a;
    end
    check("first_edge_no_done", {63'b0, seen_done}, 64'd0);

    // Table-driven frames
    for (int k = 0; k < 7; k++) begin
      @(negedge aud_bclk);
      fmt_a      = vecs[k].fa;
      fmt_b      = vecs[k].fb;
      in_valid_a = vecs[k].push_a;
      in_left_a  = vecs[k].la;
      in_right_a = vecs[k].ra;
      in_valid_b = vecs[k].push_b;
      in_left_b  = vecs[k].lb;
      in_right_b = vecs[k].rb;
      #1;
      if (vecs[k].push_a) check($sformatf("row%0d_ready_a", k), {63'b0, in_ready_a}, 64'd1);
      if (vecs[k].push_b) check($sformatf("row%0d_ready_b", k), {63'b0, in_ready_b}, 64'd1);
      @(negedge aud_bclk);
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      run_frame(vecs[k].flip, vecs[k].epush, vecs[k].el, vecs[k].er, 1'b0);
      check_frame($sformatf("row%0d", k), vecs[k].xa, vecs[k].ua);
      check($sformatf("row%0d_dac_b", k), cap_b, vecs[k].xb);
      check($sformatf("row%0d_und_b", k), und_mask_b, vecs[k].ub ? 64'h1 : 64'h0);
    end

    // FIFO full: five back-to-back pushes with no LRC edge
    fmt_a = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge aud_bclk);
      in_valid_a = 1'b1;
      in_left_a  = 24'h100000 + 24'(k);
      in_right_a = 24'h200000 + 24'(k);
      #1;
      acc = in_ready_a;
      check($sformatf("full_push%0d_ready", k), {63'b0, acc}, (k <= 4) ? 64'd1 : 64'd0);
    end
    @(negedge aud_bclk);
    in_valid_a = 1'b0;
    #1;
    check("full_ready_low", {63'b0, in_ready_a}, 64'd0);
    for (int k = 1; k <= 5; k++) begin
      run_frame(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
      if (k == 1) check("full_ready_after_pop", {63'b0, in_ready_a}, 64'd1);
      if (k <= 4)
        check_frame($sformatf("full_frame%0d", k),
                    {24'h100000 + 24'(k), 8'h00, 24'h200000 + 24'(k), 8'h00}, 1'b0);
      else
        check_frame("full_frame5", 64'h0, 1'b1);
    end

    // Reset at cnt=10 of the left word
    for (int k = 0; k < 4; k++) begin
      @(negedge aud_bclk);
      in_valid_a = 1'b1;
      in_left_a  = 24'hA5A5A5;
      in_right_a = 24'h5A5A5A;
    end
    @(negedge aud_bclk);
    in_valid_a = 1'b0;
    @(negedge aud_bclk);
    aud_lrc = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge aud_bclk);
      if (i == 5) in_valid_a = 1'b1;
      if (i == 6) in_valid_a = 1'b0;
    end
    #1;
    check("pre_rst_dacdat_cnt10", {63'b0, dac_a}, 64'd1);
    check("pre_rst_ready_full", {63'b0, in_ready_a}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dacdat", {63'b0, dac_a}, 64'd0);
    check("mid_rst_ready", {63'b0, in_ready_a}, 64'd1);
    check("mid_rst_done", {63'b0, done_a}, 64'd0);
    repeat (2) @(negedge aud_bclk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aud_bclk);
      if (i == 1) aud_lrc = 1'b1;
      #1;
      seen_done = seen_done | done_a;
    end
    check("post_rst_no_done", {63'b0, seen_done}, 64'd0);
    run_frame(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
    check_frame("post_rst", 64'h0, 1'b1);
    check("post_rst_dac_b", cap_b, 64'h0);

`ifdef AUDIO_TX_UNDERRUN_CNT_EN
    check("ucnt_after_1", {48'b0, ucnt_a}, 64'd1);
    run_frame(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
    run_frame(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
    check("ucnt_after_3", {48'b0, ucnt_a}, 64'd3);
    run_frame(1'b0, 1'b0, 24'h0, 24'h0, 1'b1);
    check("ucnt_clr_wins", {48'b0, ucnt_a}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Parametrised serial audio transmitter driving the codec DAC data pin. Slave to the codec-generated aud_bclk and aud_lrc.
- Generalised in word length, slot length and format (I2S or right-justified).
- Stereo sample frames arrive through a valid/ready handshake into a small FIFO, so user logic is decoupled from LRC timing. Underruns are detected and reported.

Parameters:
- WL, 24, audio word length in bits; legal range 8..32.
- SLOT, 32, bclk periods per LRC half-period; legal range 16..32; must be >= WL.
- DEPTH, 4, FIFO depth in stereo frames; power of two, 2..16.
- UNDERRUN_REPEAT, 0, 0 = send zeros on underrun; 1 = resend last frame.

Ports:
- aud_bclk  in  1  codec bit clock; sole clock of block
- rst_n  in  1  reset, asynchronous, active-low
- aud_lrc  in  1  codec LR clock; 0 = left, 1 = right; changes on bclk falling edge
- fmt  in  1  0 = I2S (one-bclk MSB delay), 1 = right-justified; sampled only at left-channel LRC edge
- in_valid  in  1  frame present
- in_ready  out  1  FIFO not full
- in_left  in  WL  left sample, two's complement
- in_right  in  WL  right sample
- aud_dacdat  out  1  serial data, driven on aud_bclk falling edge
- tx_done  out  1  one-cycle pulse: a channel word has been fully shifted
- tx_ch  out  1  channel that tx_done refers to (0 = L, 1 = R)
- underrun  out  1  one-cycle pulse: frame pop found FIFO empty

Behaviour:
- Reset values: aud_dacdat=0, tx_done=0, tx_ch=0, underrun=0, in_ready=1, FIFO empty, hold/shift registers=0, fmt_q=0, armed=0.
- Edge detect:
  - lrc_d0 is registered at posedge.
  - lrc_edge = aud_lrc ^ lrc_d0.
  - After reset, lrc_d0=0, so a high LRC produces an edge on the first clock.
- Bit counter cnt (6 bit):
  - Cleared to 0 on lrc_edge.
  - Otherwise increments and saturates at 63.
  - Never wraps.
- Left edge (lrc_edge && aud_lrc==0), at that posedge:
  - Pop FIFO head into hold{L,R}.
  - Latch fmt into fmt_q.
  - Load shift register with the left word.
  - If FIFO is empty: hold = zeros (UNDERRUN_REPEAT=0) or unchanged (=1); underrun pulses on the next cycle.
- Right edge: load shift register with hold.R. No pop.
- Output, at negedge, from shift word w and cnt:
  - I2S: dacdat = w[WL-1-cnt] for cnt<WL, else 0. The MSB is therefore sampled by the codec at the 2nd posedge after the LRC change.
  - RJ: let off=SLOT-WL. dacdat = w[WL-1] (sign extension) for cnt<off; w[WL-1-(cnt-off)] for off<=cnt<SLOT; 0 for cnt>=SLOT.
- tx_done/tx_ch:
  - Registered pulse on the posedge after each lrc_edge, reporting the channel that just ended (tx_ch = ~aud_lrc at that edge).
  - Suppressed for the first edge after reset; armed is set by the first edge.
- FIFO handshake:
  - Push when in_valid && in_ready.
  - in_ready = !full, combinational from occupancy.
  - Push while full is ignored, even if a pop occurs in the same cycle (no pass-through).
  - Push and pop in the same cycle when not empty/full: occupancy unchanged.
  - Push and pop on an empty FIFO: counts as underrun; the pushed frame is stored for the next pop (no bypass).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- Mid-frame fmt changes take effect only at the next left edge.
- LRC half-periods shorter than the word truncate the word silently, with no error.
- Reset mid-frame: aud_dacdat returns to 0 immediately, FIFO contents are lost, and the next valid left edge restarts cleanly.

Optional Feature:
- Macro AUDIO_TX_UNDERRUN_CNT_EN.
- When defined: adds output underrun_cnt [15:0] and input underrun_clr [0:0].
  - The counter increments on each underrun pulse and saturates at 16'hFFFF.
  - underrun_clr clears it synchronously; clear wins over a simultaneous increment.
  - Reset value 0.
- When not defined: neither port exists, and the underrun pulse is the only indication.

Decomposition:
- Package audio_pkg holds:
  - FMT_I2S=1'b0 and FMT_RJ=1'b1;
  - CNT_W=6 and CNT_MAX=63;
  - function clog2 for pointer widths.
- One sub-module, audio_tx_fifo: single-clock, DEPTH x 2*WL, valid/ready write, pop/empty read.
- The top module holds edge detect, counter, shifter, serialiser and status.

Test Plan:
- WL=24, SLOT=32, fmt=0; push L=24'hA5A5A5, R=24'h5A5A5A; LRC 64-bclk frame -> dacdat bits match MSB-first from 2nd posedge after each LRC change, then zeros for cnt 24..31; tx_done pulses with tx_ch=0 then 1.
- fmt=1, WL=16, SLOT=32, L=16'h8001 -> 16 leading 1s (sign extension), then 1000_0000_0000_0001, with the LSB in the last slot bit.
- No pushes after reset, UNDERRUN_REPEAT=0 -> underrun pulses once per frame and dacdat stays 0; with UNDERRUN_REPEAT=1 after one frame pushed -> the same frame repeats.
- DEPTH=4: push 5 frames back-to-back with no LRC -> in_ready drops after the 4th and the 5th is not accepted; after one left edge, in_ready=1.
- Assert rst_n low at cnt=10 of the left word -> dacdat=0 immediately, in_ready=1, no tx_done on the first edge after release.
- With AUDIO_TX_UNDERRUN_CNT_EN: 3 underruns -> underrun_cnt=3; underrun_clr coincident with a 4th underrun -> underrun_cnt=0.
